// File: rtl/cbus_arb_pkg.sv
// Shared types and limits for the CBus round-robin arbiter.
package cbus_arb_pkg;

  localparam int CBUS_NREQ_MAX = 8;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [7:0]  wstrobe;
  } cbus_req_t;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDX_W:0]   sum  [NREQ];
  logic [IDX_W-1:0] cand [NREQ];
  logic [NREQ-1:0]  rot;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_rot
    assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum[gi] - (IDX_W+1)'(NREQ))
                                                   : IDX_W'(sum[gi]);
    assign rot[gi]  = req[cand[gi]];
  end

  assign any = |req;

  always_comb begin
    idx = cand[0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus master port between NREQ requesters.
// Optional watchdog enabled by defining CBUS_ARB_TIMEOUT_EN.
module cbus_arbiter
  import cbus_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
`ifdef CBUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     m_valid,
  input  logic [NREQ*64-1:0]  m_addr,
  input  logic [NREQ*64-1:0]  m_wdata,
  input  logic [NREQ*3-1:0]   m_size,
  input  logic [NREQ*2-1:0]   m_burst,
  input  logic [NREQ*8-1:0]   m_len,
  input  logic [NREQ*8-1:0]   m_wstrobe,
  output logic [NREQ*64-1:0]  m_rdata,
  output logic [NREQ-1:0]     m_ready,
  output logic [NREQ-1:0]     m_last,
  output logic                valid,
  output logic [63:0]         addr,
  output logic [63:0]         wdata,
  output logic [2:0]          size,
  output logic [1:0]          burst,
  output logic [7:0]          len,
  output logic [7:0]          wstrobe,
  input  logic [63:0]         rdata,
  input  logic                ready,
  input  logic                last
`ifdef CBUS_ARB_TIMEOUT_EN
  , output logic              timeout_err
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             busy;
  logic             done;
  cbus_req_t        req_arr [NREQ];
  cbus_req_t        out_req;

`ifdef CBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req (m_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_arr[gi] = '{addr:    m_addr[64*gi +: 64],
                           wdata:   m_wdata[64*gi +: 64],
                           size:    m_size[3*gi +: 3],
                           burst:   m_burst[2*gi +: 2],
                           len:     m_len[8*gi +: 8],
                           wstrobe: m_wstrobe[8*gi +: 8]};
    // Read data fans out to everyone; only the owner's ready makes it meaningful.
    assign m_rdata[64*gi +: 64] = busy ? rdata : 64'd0;
    assign m_ready[gi] = busy && (owner_q == IDX_W'(gi)) && ready;
    assign m_last[gi]  = busy && (owner_q == IDX_W'(gi)) && last;
  end

  assign busy    = (state_q == BUSY);
  assign out_req = busy ? req_arr[owner_q] : '0;
  assign valid   = busy && m_valid[owner_q];
  assign addr    = out_req.addr;
  assign wdata   = out_req.wdata;
  assign size    = out_req.size;
  assign burst   = out_req.burst;
  assign len     = out_req.len;
  assign wstrobe = out_req.wstrobe;

  assign owner_inc = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
  assign done      = valid && ready && last;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef CBUS_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = BUSY;
`ifdef CBUS_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (done) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
`ifdef CBUS_ARB_TIMEOUT_EN
        else if (ready) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LIM) begin
          state_d       = IDLE;
          rr_ptr_d      = owner_inc;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
`ifdef CBUS_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef CBUS_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scenario bench for cbus_arbiter: grant latency, rotation, hold, reset and
// (with CBUS_ARB_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_cbus_arbiter;

  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    m_valid;
  logic [NREQ*64-1:0] m_addr, m_wdata, m_rdata;
  logic [NREQ*3-1:0]  m_size;
  logic [NREQ*2-1:0]  m_burst;
  logic [NREQ*8-1:0]  m_len, m_wstrobe;
  logic [NREQ-1:0]    m_ready, m_last;
  logic               valid, ready, last;
  logic [63:0]        addr, wdata, rdata;
  logic [2:0]         size;
  logic [1:0]         burst;
  logic [7:0]         len, wstrobe;
`ifdef CBUS_ARB_TIMEOUT_EN
  logic               timeout_err;
`endif

  typedef struct {
    int          owner;
    logic [63:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(
    .NREQ(NREQ)
`ifdef CBUS_ARB_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_burst(m_burst), .m_len(m_len), .m_wstrobe(m_wstrobe),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_last(m_last),
    .valid(valid), .addr(addr), .wdata(wdata), .size(size), .burst(burst),
    .len(len), .wstrobe(wstrobe), .rdata(rdata), .ready(ready), .last(last)
`ifdef CBUS_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] ln, input logic [7:0] ws);
    m_valid[i]           = v;
    m_addr[64*i +: 64]   = a;
    m_wdata[64*i +: 64]  = wd;
    m_size[3*i +: 3]     = 3'd3;
    m_burst[2*i +: 2]    = 2'd1;
    m_len[8*i +: 8]      = ln;
    m_wstrobe[8*i +: 8]  = ws;
  endtask

  task automatic slave(input logic r, input logic l, input logic [63:0] d);
    ready = r;
    last  = l;
    rdata = d;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_size = '0;
    m_burst = '0; m_len = '0; m_wstrobe = '0;
    set_req(0, 1'b1, 64'h1234, 64'h0, 8'd0, 8'h0);
    slave(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001);
    repeat (3) tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_cmp++; if (addr !== 64'd0) begin n_err++; $display("FAIL reset_addr got=%h want=0", addr); end
    n_cmp++; if (m_ready !== 2'b00) begin n_err++; $display("FAIL reset_m_ready got=%b want=00", m_ready); end
    n_cmp++; if (m_last !== 2'b00) begin n_err++; $display("FAIL reset_m_last got=%b want=00", m_last); end
    n_cmp++; if (m_rdata !== '0) begin n_err++; $display("FAIL reset_m_rdata got=%h want=0", m_rdata); end
    reset = 1'b0;
    m_valid = '0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL idle_no_req_valid got=%b want=0", valid); end
  endtask

  task automatic test_single_read();
    exp_t e;
    int   pulses = 0;
    set_req(0, 1'b1, 64'h1000, 64'h0, 8'd3, 8'h00);
    sb_q.push_back('{0, 64'h1000});
    settle();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL sr_latency got=%b want=0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1 || addr !== 64'h1000 || len !== 8'd3 || size !== 3'd3)
      begin n_err++; $display("FAIL sr_grant valid=%b addr=%h len=%0d size=%0d want 1/1000/3/3", valid, addr, len, size); end
    for (int b = 0; b < 4; b++) begin
      slave(1'b1, (b == 3), 64'hA000 + 64'(b));
      settle();
      n_cmp++; if (m_ready !== 2'b01) begin n_err++; $display("FAIL sr_m_ready beat=%0d got=%b want=01", b, m_ready); end
      n_cmp++; if (m_last !== ((b == 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL sr_m_last beat=%0d got=%b", b, m_last); end
      n_cmp++; if (m_rdata[63:0] !== 64'hA000 + 64'(b) || m_rdata[127:64] !== 64'hA000 + 64'(b))
        begin n_err++; $display("FAIL sr_m_rdata beat=%0d got=%h want both slices %h", b, m_rdata, 64'hA000 + 64'(b)); end
      if (m_ready[0]) pulses++;
      if (b == 3) begin
        if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL sr_sb_underflow got=empty want=entry"); end
        else begin
          e = sb_q.pop_front(); n_cmp++;
          if (onehot_idx(m_last) != e.owner || addr !== e.addr)
            begin n_err++; $display("FAIL sr_done owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
        end
      end
      tick();
    end
    m_valid[0] = 1'b0;
    slave(1'b0, 1'b0, 64'h5555);
    settle();
    n_cmp++; if (valid !== 1'b0 || m_ready !== 2'b00) begin n_err++; $display("FAIL sr_release valid=%b m_ready=%b want 0/00", valid, m_ready); end
    n_cmp++; if (pulses != 4) begin n_err++; $display("FAIL sr_pulses got=%0d want=4", pulses); end
    tick();
  endtask

  task automatic test_contention();
    exp_t e;
    logic [63:0] want_addr;
    set_req(0, 1'b1, 64'h100, 64'h0, 8'd0, 8'h00);
    set_req(1, 1'b1, 64'h200, 64'h0, 8'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) sb_q.push_back('{k % 2, (k % 2) ? 64'h200 : 64'h100});
    settle();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ct_post_reset_valid got=%b want=0", valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      want_addr = (k % 2) ? 64'h200 : 64'h100;
      n_cmp++; if (valid !== 1'b1 || addr !== want_addr)
        begin n_err++; $display("FAIL ct_grant k=%0d valid=%b addr=%h want 1/%h", k, valid, addr, want_addr); end
      slave(1'b1, 1'b1, 64'(k));
      settle();
      if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL ct_sb_underflow k=%0d got=empty want=entry", k); end
      else begin
        e = sb_q.pop_front(); n_cmp++;
        if (onehot_idx(m_last) != e.owner || addr !== e.addr)
          begin n_err++; $display("FAIL ct_done k=%0d owner=%0d addr=%h want owner=%0d addr=%h", k, onehot_idx(m_last), addr, e.owner, e.addr); end
      end
      tick();
      if (k == 3) m_valid = '0;
      slave(1'b0, 1'b0, 64'd0);
      settle();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ct_gap k=%0d got=%b want=0", k, valid); end
      if (k < 3) tick();
    end
    tick();
  endtask

  task automatic test_write_wait();
    exp_t e;
    logic rdy, lst;
    logic [1:0] want_rdy;
    set_req(1, 1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'd3, 8'hFF);
    sb_q.push_back('{1, 64'h8000_0000});
    sb_q.push_back('{0, 64'h300});
    tick();
    set_req(0, 1'b1, 64'h300, 64'h0, 8'd0, 8'h00);
    for (int b = 0; b < 5; b++) begin
      rdy = (b != 1);
      lst = (b == 4);
      want_rdy = {rdy, 1'b0};
      slave(rdy, lst, 64'hBEEF);
      settle();
      n_cmp++; if (valid !== 1'b1 || addr !== 64'h8000_0000 || wdata !== 64'h1122_3344_5566_7788 || wstrobe !== 8'hFF || len !== 8'd3)
        begin n_err++; $display("FAIL ww_fields b=%0d valid=%b addr=%h wdata=%h wstrobe=%h len=%0d", b, valid, addr, wdata, wstrobe, len); end
      n_cmp++; if (m_ready !== want_rdy) begin n_err++; $display("FAIL ww_m_ready b=%0d got=%b want=%b", b, m_ready, want_rdy); end
      if (lst) begin
        if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL ww_sb_underflow got=empty want=entry"); end
        else begin
          e = sb_q.pop_front(); n_cmp++;
          if (onehot_idx(m_last) != e.owner || addr !== e.addr)
            begin n_err++; $display("FAIL ww_done1 owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
        end
      end
      tick();
    end
    m_valid[1] = 1'b0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ww_gap got=%b want=0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1 || addr !== 64'h300 || wstrobe !== 8'h00)
      begin n_err++; $display("FAIL ww_req0_grant valid=%b addr=%h wstrobe=%h want 1/300/00", valid, addr, wstrobe); end
    slave(1'b1, 1'b1, 64'd0);
    settle();
    if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL ww_sb_underflow2 got=empty want=entry"); end
    else begin
      e = sb_q.pop_front(); n_cmp++;
      if (onehot_idx(m_last) != e.owner || addr !== e.addr)
        begin n_err++; $display("FAIL ww_done0 owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
    end
    tick();
    m_valid[0] = 1'b0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
  endtask

  task automatic test_drop_valid();
    exp_t e;
    logic v0_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic rdy_tab[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic lst_tab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_req(0, 1'b1, 64'h500, 64'h0, 8'd3, 8'h00);
    sb_q.push_back('{0, 64'h500});
    sb_q.push_back('{1, 64'h400});
    tick();
    set_req(1, 1'b1, 64'h400, 64'h0, 8'd0, 8'h00);
    for (int c = 0; c < 6; c++) begin
      m_valid[0] = v0_tab[c];
      slave(rdy_tab[c], lst_tab[c], 64'd0);
      settle();
      n_cmp++; if (valid !== v0_tab[c] || addr !== 64'h500 || m_ready[1] !== 1'b0)
        begin n_err++; $display("FAIL dv_hold c=%0d valid=%b addr=%h m_ready1=%b want %b/500/0", c, valid, addr, m_ready[1], v0_tab[c]); end
      if (lst_tab[c]) begin
        if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL dv_sb_underflow got=empty want=entry"); end
        else begin
          e = sb_q.pop_front(); n_cmp++;
          if (onehot_idx(m_last) != e.owner || addr !== e.addr)
            begin n_err++; $display("FAIL dv_done0 owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
        end
      end
      tick();
    end
    m_valid[0] = 1'b0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
    slave(1'b1, 1'b1, 64'd0);
    settle();
    if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL dv_sb_underflow2 got=empty want=entry"); end
    else begin
      e = sb_q.pop_front(); n_cmp++;
      if (valid !== 1'b1 || onehot_idx(m_last) != e.owner || addr !== e.addr)
        begin n_err++; $display("FAIL dv_done1 valid=%b owner=%0d addr=%h want owner=%0d addr=%h", valid, onehot_idx(m_last), addr, e.owner, e.addr); end
    end
    tick();
    m_valid[1] = 1'b0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // A completed req0 transaction moves the pointer to 1 before the abort.
    set_req(0, 1'b1, 64'h600, 64'h0, 8'd0, 8'h00);
    sb_q.push_back('{0, 64'h600});
    tick();
    slave(1'b1, 1'b1, 64'd0);
    settle();
    if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL rm_sb_underflow got=empty want=entry"); end
    else begin
      e = sb_q.pop_front(); n_cmp++;
      if (onehot_idx(m_last) != e.owner || addr !== e.addr)
        begin n_err++; $display("FAIL rm_pre owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
    end
    tick();
    m_valid[0] = 1'b0;
    slave(1'b0, 1'b0, 64'd0);
    set_req(1, 1'b1, 64'h700, 64'h0, 8'd3, 8'h00);
    tick();
    slave(1'b1, 1'b0, 64'hCAFE);
    settle();
    n_cmp++; if (m_ready !== 2'b10 || addr !== 64'h700) begin n_err++; $display("FAIL rm_beat1 m_ready=%b addr=%h want 10/700", m_ready, addr); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (valid !== 1'b0 || m_ready !== 2'b00 || m_last !== 2'b00 || m_rdata !== '0 || addr !== 64'd0)
      begin n_err++; $display("FAIL rm_after_reset valid=%b m_ready=%b m_last=%b m_rdata=%h addr=%h want all 0", valid, m_ready, m_last, m_rdata, addr); end
    reset = 1'b0;
    set_req(0, 1'b1, 64'h800, 64'h0, 8'd0, 8'h00);
    sb_q.push_back('{0, 64'h800});
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
    n_cmp++; if (valid !== 1'b1 || addr !== 64'h800) begin n_err++; $display("FAIL rm_first_grant valid=%b addr=%h want 1/800", valid, addr); end
    slave(1'b1, 1'b1, 64'd0);
    settle();
    if (sb_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL rm_sb_underflow2 got=empty want=entry"); end
    else begin
      e = sb_q.pop_front(); n_cmp++;
      if (onehot_idx(m_last) != e.owner || addr !== e.addr)
        begin n_err++; $display("FAIL rm_done owner=%0d addr=%h want owner=%0d addr=%h", onehot_idx(m_last), addr, e.owner, e.addr); end
    end
    tick();
    m_valid = '0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
  endtask

`ifdef CBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit seen = 1'b0;
    set_req(0, 1'b1, 64'h900, 64'h0, 8'd0, 8'h00);
    slave(1'b0, 1'b0, 64'd0);
    settle();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_idle got=%b want=0", timeout_err); end
    tick();
    set_req(1, 1'b1, 64'hA00, 64'h0, 8'd0, 8'h00);
    for (int c = 0; c < 64 && !seen; c++) begin
      if (timeout_err) seen = 1'b1;
      else begin
        if (valid) n++;
        tick();
      end
    end
    n_cmp++; if (!seen || n != 16) begin n_err++; $display("FAIL to_pulse seen=%b busy_cycles=%0d want 1/16", seen, n); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0 || valid !== 1'b1 || addr !== 64'hA00)
      begin n_err++; $display("FAIL to_next err=%b valid=%b addr=%h want 0/1/a00", timeout_err, valid, addr); end
    slave(1'b1, 1'b1, 64'd0);
    settle();
    tick();
    m_valid = '0;
    slave(1'b0, 1'b0, 64'd0);
    settle();
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_wait();
    test_drop_valid();
    test_reset_mid();
`ifdef CBUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
